// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan stage: digit count,
// segment patterns and field-to-digit masks.
package seg_scan_pkg;

   localparam int unsigned NUM_DIGITS = 6;

   // Segment patterns, bit0=a ... bit6=g, active-high
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Digits covered by each editable field
   localparam logic [5:0] FIELD_SEC  = 6'b000011;
   localparam logic [5:0] FIELD_MIN  = 6'b001100;
   localparam logic [5:0] FIELD_HOUR = 6'b110000;

   typedef enum logic [1:0] {
      FLD_NONE,
      FLD_SEC,
      FLD_MIN,
      FLD_HOUR
   } field_e;

   function automatic logic [5:0] field_mask(input field_e f);
      case (f)
         FLD_SEC:  return FIELD_SEC;
         FLD_MIN:  return FIELD_MIN;
         FLD_HOUR: return FIELD_HOUR;
         default:  return '0;
      endcase
   endfunction

endpackage

// File: rtl/bcd7seg.sv
// Combinational BCD to seven-segment decoder; codes 10..15 show blank.
module bcd7seg
   import seg_scan_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   // Pattern lookup for one BCD digit
   always_comb begin
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed six-digit display driver for the HH:MM:SS counter.
// Digits are snapshotted once per frame, colon dots are lit outside set
// mode, and the edited field blinks while set mode is active.
module seg_scan
   import seg_scan_pkg::*;
#(
   parameter int unsigned SCAN_DIV      = 2,
   parameter int unsigned BLINK_HALF    = 250,
   parameter bit          HOUR_LZ_BLANK = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   input  logic [3:0] d4,
   input  logic [3:0] d5,
   input  logic       set_mode,
   input  logic       sel_hour,
   input  logic       sel_min,
   input  logic       sel_sec,
   output logic [6:0] seg,
   output logic [5:0] dig_sel,
   output logic       dp
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       scan_q, scan_d;
   logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_ph_q, blink_ph_d;
   logic [3:0]       snap_q [NUM_DIGITS];
   logic [3:0]       din    [NUM_DIGITS];
   logic [6:0]       seg_q, seg_d;
   logic [5:0]       dig_q, dig_d;
   logic             dp_q, dp_d;

   logic [2:0]       idx;
   logic             frame_end;
   logic [3:0]       cur_digit;
   logic [6:0]       cur_seg;
   field_e           field;
   logic [5:0]       fmask;
   logic             lz_blank;
   logic             blink_blank;

   assign din[0] = d0;
   assign din[1] = d1;
   assign din[2] = d2;
   assign din[3] = d3;
   assign din[4] = d4;
   assign din[5] = d5;

   // Scan divider, digit index and blink timer next-state
   always_comb begin
      idx       = (scan_q < 3'(NUM_DIGITS)) ? scan_q : 3'd0;
      frame_end = (div_q == DIV_LAST) && (scan_q == 3'd5);
      div_d     = div_q + 1'b1;
      scan_d    = idx;
      if (div_q == DIV_LAST) begin
         div_d  = '0;
         scan_d = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end
      blink_cnt_d = blink_cnt_q + 1'b1;
      blink_ph_d  = blink_ph_q;
      if (!set_mode) begin
         blink_cnt_d = '0;
         blink_ph_d  = 1'b1;
      end else if (blink_cnt_q == BLK_LAST) begin
         blink_cnt_d = '0;
         blink_ph_d  = ~blink_ph_q;
      end
   end

   // Select the current snapshot digit for the shared decoder
   always_comb begin
      case (idx)
         3'd0:    cur_digit = snap_q[0];
         3'd1:    cur_digit = snap_q[1];
         3'd2:    cur_digit = snap_q[2];
         3'd3:    cur_digit = snap_q[3];
         3'd4:    cur_digit = snap_q[4];
         3'd5:    cur_digit = snap_q[5];
         default: cur_digit = snap_q[0];
      endcase
   end

   bcd7seg u_dec (
      .bcd_i (cur_digit),
      .seg_o (cur_seg)
   );

   // Field priority, blanking and next pin values
   always_comb begin
      if (sel_hour)     field = FLD_HOUR;
      else if (sel_min) field = FLD_MIN;
      else if (sel_sec) field = FLD_SEC;
      else              field = FLD_NONE;
      fmask       = field_mask(field);
      lz_blank    = HOUR_LZ_BLANK && (idx == 3'd5) && (cur_digit == 4'd0);
      blink_blank = set_mode && !blink_ph_q && fmask[idx];
      seg_d       = (lz_blank || blink_blank) ? SEG_BLANK : cur_seg;
      dig_d       = 6'b000001 << idx;
      dp_d        = ((idx == 3'd2) || (idx == 3'd4)) && !set_mode;
   end

   // State, snapshot and registered output update
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q       <= '0;
         scan_q      <= '0;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b1;
         for (int unsigned i = 0; i < NUM_DIGITS; i++) snap_q[i] <= '0;
         seg_q       <= '0;
         dig_q       <= '0;
         dp_q        <= 1'b0;
      end else begin
         div_q       <= div_d;
         scan_q      <= scan_d;
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
         if (frame_end) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) snap_q[i] <= din[i];
         end
         seg_q       <= seg_d;
         dig_q       <= dig_d;
         dp_q        <= dp_d;
      end
   end

   assign seg     = seg_q;
   assign dig_sel = dig_q;
   assign dp      = dp_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: a cycle model pushes expected pins
// into a scoreboard each clock, plus table vectors and corner sequences.
module tb_seg_scan;

   localparam int unsigned SD = 2;
   localparam int unsigned BH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0, d4 = '0, d5 = '0;
   logic       set_mode = 1'b0, sel_hour = 1'b0, sel_min = 1'b0, sel_sec = 1'b0;
   logic [6:0] seg;
   logic [5:0] dig_sel;
   logic       dp;

   always #5 clk = ~clk;

   seg_scan #(.SCAN_DIV(SD), .BLINK_HALF(BH), .HOUR_LZ_BLANK(1'b1)) dut (
      .clk(clk), .rst(rst),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
      .set_mode(set_mode), .sel_hour(sel_hour), .sel_min(sel_min), .sel_sec(sel_sec),
      .seg(seg), .dig_sel(dig_sel), .dp(dp)
   );

   typedef struct packed {
      logic [6:0] seg;
      logic [5:0] dig;
      logic       dp;
   } out_t;

   typedef struct {
      logic [23:0] digs;   // {d5,d4,d3,d2,d1,d0}
      logic [6:0]  exp0;
      logic [6:0]  exp5;
   } vec_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   out_t sb_q[$];

   int         m_div, m_scan, m_bcnt;
   logic       m_bph;
   logic [3:0] m_snap [6];

   function automatic logic [6:0] ref_seg(input logic [3:0] v);
      case (v)
         4'd0: return 7'b0111111;
         4'd1: return 7'b0000110;
         4'd2: return 7'b1011011;
         4'd3: return 7'b1001111;
         4'd4: return 7'b1100110;
         4'd5: return 7'b1101101;
         4'd6: return 7'b1111101;
         4'd7: return 7'b0000111;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_digits(input logic [23:0] v);
      {d5, d4, d3, d2, d1, d0} = v;
   endtask

   // One clock: model predicts the pins, scoreboard compares them
   task automatic step();
      out_t       e, got;
      logic [3:0] dn [6];
      logic       infld, blank;
      int         idx;
      @(posedge clk);
      dn = '{d0, d1, d2, d3, d4, d5};
      if (rst) begin
         e = '0;
         m_div = 0; m_scan = 0; m_bcnt = 0; m_bph = 1'b1;
         for (int i = 0; i < 6; i++) m_snap[i] = 4'd0;
      end else begin
         idx = m_scan;
         if (sel_hour)     infld = (idx >= 4);
         else if (sel_min) infld = (idx == 2) || (idx == 3);
         else if (sel_sec) infld = (idx <= 1);
         else              infld = 1'b0;
         blank = (idx == 5 && m_snap[5] == 4'd0) || (set_mode && !m_bph && infld);
         e.seg = blank ? 7'b0 : ref_seg(m_snap[idx]);
         e.dig = 6'(1) << idx;
         e.dp  = ((idx == 2) || (idx == 4)) && !set_mode;
         if (m_div == int'(SD) - 1) begin
            m_div = 0;
            if (m_scan == 5) begin
               m_scan = 0;
               for (int i = 0; i < 6; i++) m_snap[i] = dn[i];
            end else begin
               m_scan++;
            end
         end else begin
            m_div++;
         end
         if (!set_mode) begin
            m_bcnt = 0; m_bph = 1'b1;
         end else if (m_bcnt == int'(BH) - 1) begin
            m_bcnt = 0; m_bph = !m_bph;
         end else begin
            m_bcnt++;
         end
      end
      sb_q.push_back(e);
      #1;
      got = {seg, dig_sel, dp};
      e = sb_q.pop_front();
      chk("sb_seg", 32'(got.seg), 32'(e.seg));
      chk("sb_dig_sel", 32'(got.dig), 32'(e.dig));
      chk("sb_dp", 32'(got.dp), 32'(e.dp));
   endtask

   // Step until the given digit enable first appears (bounded)
   task automatic wait_dig(input logic [5:0] target, input string name);
      logic [5:0] prev;
      int         n;
      n = 0;
      prev = dig_sel;
      do begin
         prev = dig_sel;
         step();
         n++;
      end while (!(dig_sel === target && prev !== target) && n < 40);
      chk(name, 32'(dig_sel), 32'(target));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [5];
      int   hb, hv, n;
      logic done;

      vecs[0] = '{24'h543210, 7'b0111111, 7'b1101101};
      vecs[1] = '{24'h099876, 7'b1111101, 7'b0000000};
      vecs[2] = '{24'h235959, 7'b1101111, 7'b1011011};
      vecs[3] = '{24'h10000F, 7'b0000000, 7'b0000110};
      vecs[4] = '{24'h00000A, 7'b0000000, 7'b0000000};

      // Reset and first frames
      set_digits(24'h154321);
      rst = 1'b1;
      repeat (3) step();
      chk("rst_seg", 32'(seg), 0);
      chk("rst_dig_sel", 32'(dig_sel), 0);
      chk("rst_dp", 32'(dp), 0);
      rst = 1'b0;
      step();
      chk("f1_d0_seg", 32'(seg), 32'(7'b0111111));
      chk("f1_d0_dig", 32'(dig_sel), 32'(6'b000001));
      repeat (9) step();
      step();
      chk("f1_d5_seg", 32'(seg), 0);
      chk("f1_d5_dig", 32'(dig_sel), 32'(6'b100000));
      step();
      step();
      chk("f2_d0_seg", 32'(seg), 32'(7'b0000110));
      chk("f2_d0_dig", 32'(dig_sel), 32'(6'b000001));
      step();
      chk("f2_d0_hold", 32'(dig_sel), 32'(6'b000001));
      step();
      chk("f2_d1_seg", 32'(seg), 32'(7'b1011011));
      chk("f2_d1_dig", 32'(dig_sel), 32'(6'b000010));

      // Tear guard: changes at digit 2 wait for the next frame
      set_digits(24'h154323);
      wait_dig(6'b000001, "tear_w0");
      wait_dig(6'b000001, "tear_w1");
      chk("tear_pre", 32'(seg), 32'(7'b1001111));
      wait_dig(6'b000100, "tear_w2");
      set_digits(24'h164324);
      wait_dig(6'b010000, "tear_w3");
      chk("tear_hold_d4", 32'(seg), 32'(7'b1101101));
      wait_dig(6'b000001, "tear_w4");
      chk("tear_next_d0", 32'(seg), 32'(7'b1100110));
      wait_dig(6'b010000, "tear_w5");
      chk("tear_next_d4", 32'(seg), 32'(7'b1111101));

      // Decode table
      for (int v = 0; v < 5; v++) begin
         set_digits(vecs[v].digs);
         repeat (24) step();
         wait_dig(6'b000001, "vec_w0");
         chk("vec_d0", 32'(seg), 32'(vecs[v].exp0));
         wait_dig(6'b100000, "vec_w5");
         chk("vec_d5", 32'(seg), 32'(vecs[v].exp5));
      end

      // Colon and leading zero
      set_digits(24'h090000);
      repeat (24) step();
      wait_dig(6'b000001, "colon_w");
      for (int j = 1; j < 12; j++) begin
         step();
         chk("colon_dp", 32'(dp), 32'(((j / 2) == 2) || ((j / 2) == 4)));
         if (j / 2 == 5) chk("lz_seg", 32'(seg), 0);
      end

      // Blink on the hour field (hour wins over minute)
      set_digits(24'h154321);
      repeat (24) step();
      set_mode = 1'b1; sel_min = 1'b1; sel_hour = 1'b1;
      hb = 0; hv = 0;
      for (int j = 0; j < 48; j++) begin
         step();
         chk("set_dp", 32'(dp), 0);
         if (dig_sel[3:2] != 2'b00) chk("min_visible", 32'(seg == 7'b0), 0);
         if (dig_sel[5:4] != 2'b00) begin
            if (seg == 7'b0) hb++; else hv++;
         end
      end
      chk("hour_blanked", 32'(hb > 0), 1);
      chk("hour_shown", 32'(hv > 0), 1);
      n = 0; done = 1'b0;
      while (!done && n < 200) begin
         logic [5:0] prev;
         prev = dig_sel;
         step();
         n++;
         done = (dig_sel === 6'b010000) && (prev !== 6'b010000) && (seg === 7'b0);
      end
      chk("blank_found", 32'(done), 1);
      set_mode = 1'b0;
      step();
      chk("unblink_dig", 32'(dig_sel), 32'(6'b010000));
      chk("unblink_seg", 32'(seg), 32'(7'b1101101));
      chk("unblink_dp", 32'(dp), 1);
      sel_min = 1'b0; sel_hour = 1'b0;

      // Invalid BCD code on digit 3
      set_digits(24'h15C321);
      repeat (24) step();
      wait_dig(6'b000100, "inv_w2");
      chk("inv_d2", 32'(seg), 32'(7'b1001111));
      wait_dig(6'b001000, "inv_w3");
      chk("inv_d3", 32'(seg), 0);
      wait_dig(6'b010000, "inv_w4");
      chk("inv_d4", 32'(seg), 32'(7'b1101101));

      // Mid-scan reset
      set_digits(24'h154321);
      repeat (24) step();
      wait_dig(6'b001000, "mrst_w");
      rst = 1'b1;
      step();
      chk("mrst_seg", 32'(seg), 0);
      chk("mrst_dig", 32'(dig_sel), 0);
      chk("mrst_dp", 32'(dp), 0);
      rst = 1'b0;
      step();
      chk("mrst_d0_dig", 32'(dig_sel), 32'(6'b000001));
      chk("mrst_d0_seg", 32'(seg), 32'(7'b0111111));
      wait_dig(6'b100000, "mrst_w5");
      chk("mrst_d5_seg", 32'(seg), 0);
      repeat (24) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
Downstream display stage for the 24 h clock counter. Takes six live BCD digits (HH:MM:SS) and the set-mode controls, and time-multiplexes them onto one shared 7-segment bus with one-hot digit enables. Snapshots the digits once per frame so a refresh frame never tears across a carry. Blinks the field being edited while the clock is in set mode.

Parameters:
SCAN_DIV, 2, clk cycles each digit is held (2 @1000 Hz gives a 12 ms frame, ~83 Hz refresh)
BLINK_HALF, 250, clk cycles per blink half-period (250 @1000 Hz gives a 2 Hz blink)
HOUR_LZ_BLANK, 1, 1 = blank the hour-tens digit when its value is 0

Ports:
clk  in  1  system clock, 1000 Hz, the same clock as the counter
rst  in  1  synchronous, active-high reset
d0  in  4  seconds units, BCD
d1  in  4  seconds tens, BCD
d2  in  4  minutes units, BCD
d3  in  4  minutes tens, BCD
d4  in  4  hours units, BCD
d5  in  4  hours tens, BCD
set_mode  in  1  clock is in set mode (the counter's set_clr level)
sel_hour  in  1  hour field selected for editing
sel_min  in  1  minute field selected
sel_sec  in  1  second field selected
seg  out  7  segments, active-high; bit0=a … bit6=g
dig_sel  out  6  one-hot digit enable, active-high; bit i drives digit d_i
dp  out  1  decimal point / colon segment, active-high

Behaviour:
- Reset is synchronous, active-high, one clock, and has priority over everything else. It sets:
  - div_cnt=0, scan_idx=0, blink_cnt=0, blink_phase=1 (visible)
  - all six snapshot digits = 0
  - seg=7'b0000000, dig_sel=6'b000000, dp=0
- Divider:
  - div_cnt counts 0..SCAN_DIV-1.
  - At the terminal value: div_cnt←0 and scan_idx advances 0→1→…→5→0.
  - Values outside 0..5 are unreachable. If scan_idx is ever out of range it is forced to 0.
- Snapshot:
  - When div_cnt==SCAN_DIV-1 and scan_idx==5, all six inputs are latched into the snapshot registers.
  - Digit 0 of the next frame uses the new snapshot.
  - Input changes mid-frame are invisible until the next frame.
- Outputs: all registered, with a 1-cycle latency from scan_idx to the pins. Each cycle:
  - dig_sel ← one-hot(scan_idx)
  - seg ← decode(snap[scan_idx]), or 0 if the digit is blanked
  - dp ← 1 when scan_idx ∈ {2,4} and set_mode==0, else 0
- Decode:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Codes 10..15 decode to 0000000 (blank).
- Leading zero: with HOUR_LZ_BLANK=1 and snap[5]==0, digit 5 is blanked. dig_sel still asserts for that digit.
- Blink:
  - While set_mode==0: blink_cnt held at 0, blink_phase held at 1.
  - While set_mode==1: blink_cnt counts 0..BLINK_HALF-1; at the terminal value it wraps to 0 and blink_phase toggles.
  - Because the counter is held outside set mode, entering set mode always starts in the visible phase for BLINK_HALF cycles.
- Field select:
  - Priority is hour > min > sec, the same priority the counter uses.
  - hour → digits 4,5; min → digits 2,3; sec → digits 0,1; none selected → no field.
- Blanking rule: digit i is blanked when set_mode==1, blink_phase==0, and i belongs to the selected field. Blink blanking ORs with the leading-zero and invalid-code blanking.
- Simultaneous events:
  - A snapshot and a set_mode change in the same cycle both take effect.
  - Dropping set_mode mid-blink restores visibility in the next registered output.
- The scan never stalls, and no dead cycle is inserted between digits.

Decomposition:
- Package seg_scan_pkg holds:
  - NUM_DIGITS=6
  - the 7-bit segment constants SEG_0..SEG_9 and SEG_BLANK
  - field-to-digit-mask constants: FIELD_SEC=6'b000011, FIELD_MIN=6'b001100, FIELD_HOUR=6'b110000
- One sub-module, bcd7seg: a purely combinational BCD → segment decoder, instantiated once on the muxed snapshot digit.

Test Plan (SCAN_DIV=2, BLINK_HALF=4 in sim):
1. Reset sequence: assert rst 3 cycles with inputs 1,2,3,4,5,1 → seg=0, dig_sel=0, dp=0. After release: first frame shows 0 for digits 0..4, digit 5 blank (leading zero). Frame 2 shows d0=seg 0000110 with dig_sel=000001, then 1011011 with 000010, and so on; each digit held exactly 2 cycles.
2. Tear guard: change d0 from 3 to 4 while scan_idx==2 → digit 0 still shows 1001111 for the remainder of that frame, then shows 1100110 on the next frame.
3. Colon and leading zero: inputs 0,0,0,0,9,0 → dp=1 only while dig_sel=000100 and 010000. Digit 5 has seg=0 and dig_sel=100000.
4. Blink: set_mode=1, sel_min=1, sel_hour=1 → the hour digits blank during 4-cycle windows (blinking for 4 cycles, visible for 4 cycles) while the minute digits stay visible. Dropping set_mode → hours become visible on the next registered output and dp returns.
5. Invalid BCD: d3=4'hC → seg=0000000 while dig_sel=001000; all other digits are unaffected.
6. Mid-operation reset: assert rst while scan_idx==3 → the next cycle has all outputs at 0, the snapshot is cleared, and the scan restarts at digit 0.
